// File: rtl/rr_mux_arbiter_41.sv
// Round-robin arbiter in front of a shared 4:1 data path.
// It registers the one-hot grant, the select lines {s1,s0} and busy, and gates the selected lane onto y.
module rr_mux_arbiter_41 #(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   din,
    output logic [3:0]            gnt,
    output logic                  s1,
    output logic                  s0,
    output logic                  busy,
    output logic [DATA_W-1:0]     y
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  sel_q, sel_d;
    logic        busy_q, busy_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  hold_q, hold_d;

    logic [3:0]  own_mask;
    logic [3:0]  others;
    logic [3:0]  pick_mask;
    logic [1:0]  win;

    logic [DATA_W-1:0] lane [4];

    // First set bit of mask, searching from last+1 upward modulo 4; last itself is the final candidate.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (mask[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    // In GRANT last_q always equals the owner, so one search serves idle, release and timeout.
    always_comb begin
        own_mask  = 4'b0001 << sel_q;
        others    = req & ~own_mask;
        pick_mask = (state_q == IDLE) ? req : others;
        win       = rr_pick(pick_mask, last_q);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win;
                    sel_d   = win;
                    busy_d  = 1'b1;
                    last_d  = win;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!req[sel_q] || (hold_q == HOLD_LAST)) begin
                    if (|others) begin
                        gnt_d  = 4'b0001 << win;
                        sel_d  = win;
                        last_d = win;
                        hold_d = '0;
                    end else if (!req[sel_q]) begin
                        // Select lines keep their last value while idle.
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end else begin
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            last_q  <= 2'd3;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign lane[i] = din[i*DATA_W +: DATA_W];
    end

    always_comb begin
        y = '0;
        if (busy_q) begin
            y = lane[sel_q];
        end
    end

    assign gnt  = gnt_q;
    assign s1   = sel_q[1];
    assign s0   = sel_q[0];
    assign busy = busy_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_busy_gnt:   assert property (@(posedge clk) disable iff (rst) busy_q == (|gnt_q));

endmodule

// File: tb/tb_rr_mux_arbiter_41.sv
// Directed scoreboard bench for rr_mux_arbiter_41 (DATA_W=1, MAX_HOLD=4).
// Outputs are packed as {gnt[3:0], s1, s0, busy, y}.
module tb_rr_mux_arbiter_41;
  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       y;

  logic [7:0] exp_q[$];
  int         total;
  int         bad;

  rr_mux_arbiter_41 #(.DATA_W(1), .MAX_HOLD(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .din  (din),
    .gnt  (gnt),
    .s1   (s1),
    .s0   (s0),
    .busy (busy),
    .y    (y)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got gnt/s1s0/busy/y=%b required=%b", name, $time, act, exp);
    end
  endtask

  // driver: drive at negedge, expected response after the following posedge
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] eg,
                      input logic [1:0] es, input logic eb, input logic ey);
    @(negedge clk);
    req = r;
    din = d;
    exp_q.push_back({eg, es, eb, ey});
  endtask

  // monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check("cycle", {gnt, s1, s0, busy, y}, e);
    end
  end

  initial begin
    int o;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    din   = 4'b1111;
    #2;
    check("reset_values", {gnt, s1, s0, busy, y}, 8'b0000_00_0_0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // all four requesting: 0,1,2,3,0 with four cycles each
    for (int c = 0; c < 20; c++) begin
      o = (c / 4) % 4;
      step(4'b1111, 4'b1010, 4'(1 << o), 2'(o), 1'b1, o[0]);
    end

    // asynchronous reset while requester 0 owns the path
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    #1;
    check("reset_async", {gnt, s1, s0, busy, y}, 8'b0000_00_0_0);
    @(negedge clk);
    rst = 1'b0;

    // single request on lane 2, then release to idle
    step(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);

    // requester 1 alone holds past the hold limit
    step(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);
    end
    step(4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);

    // owner 0 releases while 3 waits: handover on the same edge
    step(4'b0001, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b1001, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);

    // owner 3 times out with 0 waiting: grant wraps to 0
    for (int c = 0; c < 3; c++) begin
      step(4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);
    end
    step(4'b1001, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0000, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // a request pulse that drops before the edge is never seen
    @(negedge clk);
    req = 4'b0100;
    #2;
    req = 4'b0000;
    step(4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    check("drain", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
